// File: rtl/trig_link_pkg.sv
// Trigger link controller shared types: link state encoding and frame K-codes.
package trig_link_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOCK_WAIT = 2'd1,
        ST_SYNC      = 2'd2,
        ST_RUN       = 2'd3
    } link_state_t;

    localparam logic [7:0] K_BC = 8'hBC;
    localparam logic [7:0] K_F7 = 8'hF7;
    localparam logic [7:0] K_FB = 8'hFB;
    localparam logic [7:0] K_FD = 8'hFD;
    localparam logic [7:0] K_FC = 8'hFC;
    localparam logic [7:0] K_50 = 8'h50;

    function automatic logic [7:0] frame_sep(input logic [1:0] phase);
        logic [7:0] sep;
        sep = K_BC;
        unique case (phase)
            2'd0: sep = K_BC;
            2'd1: sep = K_F7;
            2'd2: sep = K_FB;
            2'd3: sep = K_FD;
        endcase
        return sep;
    endfunction

endpackage

// File: rtl/trig_link_lock_filter.sv
// Synchronizes PLL lock / TX sync-done and counts how long both stay high
// while the link waits for a stable lock.
module trig_link_lock_filter
    import trig_link_pkg::*;
#(
    parameter int LOCK_FILTER = 16
) (
    input  logic TRG_CLK80,
    input  logic TRG_TXRESETDONE,
    input  logic PLL_LOCK,
    input  logic TX_SYNC_DONE,
    input  logic filt_en,
    output logic ok,
    output logic filt_done
);

    localparam logic [7:0] FILT_LAST = 8'(LOCK_FILTER - 1);

    logic [1:0] pll_sync;
    logic [1:0] txd_sync;
    logic [7:0] filt_cnt;

    always_ff @(posedge TRG_CLK80 or negedge TRG_TXRESETDONE) begin
        if (!TRG_TXRESETDONE) begin
            pll_sync <= 2'b00;
            txd_sync <= 2'b00;
        end else begin
            pll_sync <= {pll_sync[0], PLL_LOCK};
            txd_sync <= {txd_sync[0], TX_SYNC_DONE};
        end
    end

    assign ok = pll_sync[1] & txd_sync[1];

    // Held at zero outside the wait window, so every entry starts fresh.
    always_ff @(posedge TRG_CLK80 or negedge TRG_TXRESETDONE) begin
        if (!TRG_TXRESETDONE) begin
            filt_cnt <= 8'd0;
        end else if (!filt_en || !ok) begin
            filt_cnt <= 8'd0;
        end else if (filt_cnt != FILT_LAST) begin
            filt_cnt <= filt_cnt + 8'd1;
        end
    end

    assign filt_done = filt_en & ok & (filt_cnt == FILT_LAST);

endmodule

// File: rtl/trig_link_ctrl.sv
// Trigger fiber link bring-up FSM and frame separator generation.
// Optional BX0 marker K-code enabled by TRIG_LINK_BC0_MARK_EN.
module trig_link_ctrl
    import trig_link_pkg::*;
#(
    parameter int SYNC_CYCLES = 256,
    parameter int LOCK_FILTER = 16
) (
    input  logic       TRG_CLK80,
    input  logic       TRG_TXRESETDONE,
    input  logic       PLL_LOCK,
    input  logic       TX_SYNC_DONE,
    input  logic       FORCE_RESYNC,
    input  logic       GEM_OVERFLOW,
    input  logic       BC0,
    output logic       TRG_RST,
    output logic       TX_SEL,
    output logic [7:0] FRM_SEP,
    output logic       LINK_READY,
    output logic [7:0] RESYNC_CNT,
    output logic [1:0] STATE
);

    localparam logic [15:0] SYNC_LAST = 16'(SYNC_CYCLES - 1);

    link_state_t state;
    link_state_t next_state;
    logic        ok;
    logic        filt_done;
    logic        rc_inc;
    logic        bc0_hit;
    logic [15:0] sync_cnt;
    logic [2:0]  frm_cnt;
    logic [7:0]  resync_cnt;
    logic        trg_rst_q;
    logic        link_ready_q;

    trig_link_lock_filter #(
        .LOCK_FILTER (LOCK_FILTER)
    ) u_lock_filter (
        .TRG_CLK80       (TRG_CLK80),
        .TRG_TXRESETDONE (TRG_TXRESETDONE),
        .PLL_LOCK        (PLL_LOCK),
        .TX_SYNC_DONE    (TX_SYNC_DONE),
        .filt_en         (state == ST_LOCK_WAIT),
        .ok              (ok),
        .filt_done       (filt_done)
    );

`ifdef TRIG_LINK_BC0_MARK_EN
    assign bc0_hit = BC0 & (state == ST_RUN);
`else
    assign bc0_hit = BC0 & 1'b0;
`endif

    always_comb begin
        next_state = state;
        rc_inc     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (ok) next_state = ST_LOCK_WAIT;
            end
            ST_LOCK_WAIT: begin
                if (!ok) next_state = ST_IDLE;
                else if (filt_done) next_state = ST_SYNC;
            end
            ST_SYNC: begin
                if (!ok) next_state = ST_IDLE;
                else if (sync_cnt == SYNC_LAST) next_state = ST_RUN;
            end
            ST_RUN: begin
                // Lock loss outranks a concurrent resync request.
                if (!ok) begin
                    next_state = ST_IDLE;
                    rc_inc     = 1'b1;
                end else if (FORCE_RESYNC) begin
                    next_state = ST_SYNC;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge TRG_CLK80 or negedge TRG_TXRESETDONE) begin
        if (!TRG_TXRESETDONE) begin
            state        <= ST_IDLE;
            sync_cnt     <= 16'd0;
            frm_cnt      <= 3'd0;
            resync_cnt   <= 8'd0;
            trg_rst_q    <= 1'b1;
            link_ready_q <= 1'b0;
        end else begin
            state <= next_state;
            if (state == ST_SYNC && next_state == ST_SYNC)
                sync_cnt <= sync_cnt + 16'd1;
            else
                sync_cnt <= 16'd0;
            if (state == ST_RUN && next_state == ST_RUN)
                frm_cnt <= bc0_hit ? 3'd1 : frm_cnt + 3'd1;
            else
                frm_cnt <= 3'd0;
            if (rc_inc && resync_cnt != 8'hFF)
                resync_cnt <= resync_cnt + 8'd1;
            trg_rst_q    <= (next_state != ST_RUN);
            link_ready_q <= (next_state == ST_RUN);
        end
    end

    always_comb begin
        FRM_SEP = frame_sep(frm_cnt[2:1]);
        if (bc0_hit)
            FRM_SEP = K_50;
        else if (GEM_OVERFLOW)
            FRM_SEP = K_FC;
    end

    assign TX_SEL     = ~frm_cnt[0];
    assign TRG_RST    = trg_rst_q;
    assign LINK_READY = link_ready_q;
    assign RESYNC_CNT = resync_cnt;
    assign STATE      = state;

endmodule

// File: doc/trig_link_ctrl.md
TRIG_LINK_CTRL -- requirements
Module: trig_link_ctrl

Interface
REQ-001 Parameter SYNC_CYCLES, default 256: number of TRG_CLK80 cycles of comma idle sent before data; legal range 1..65535.
REQ-002 Parameter LOCK_FILTER, default 16: consecutive cycles lock/sync must be stable before sync starts; legal range 1..255.
REQ-003 TRG_CLK80  in  1  80 MHz trigger link fabric clock; all logic on rising edge.
REQ-004 TRG_TXRESETDONE  in  1  reset, asynchronous, active-low; clock TRG_CLK80.
REQ-005 PLL_LOCK  in  1  TX PLL lock, asynchronous to TRG_CLK80.
REQ-006 TX_SYNC_DONE  in  1  TX phase-alignment done, asynchronous to TRG_CLK80.
REQ-007 FORCE_RESYNC  in  1  single-cycle request to re-send comma idle.
REQ-008 GEM_OVERFLOW  in  1  more than 8 clusters in the current frame.
REQ-009 BC0  in  1  bunch-crossing-zero flag.
REQ-010 TRG_RST  out  1  data reset to the fiber transmitter; 1 = send comma idle word.
REQ-011 TX_SEL  out  1  word phase; 1 = upper data word, 0 = lower word carrying the separator.
REQ-012 FRM_SEP  out  8  frame separator K-code for the lower word.
REQ-013 LINK_READY  out  1  high only in RUN.
REQ-014 RESYNC_CNT  out  8  count of lock losses in RUN, saturating.
REQ-015 STATE  out  2  state encoding: IDLE=0, LOCK_WAIT=1, SYNC=2, RUN=3.

Function
REQ-016 PLL_LOCK and TX_SYNC_DONE shall each pass a 2-flop synchronizer; "ok" = both synchronized values high.
REQ-017 IDLE -> LOCK_WAIT when ok=1; filter counter cleared on entry.
REQ-018 LOCK_WAIT: counter increments each cycle ok=1; ok=0 -> IDLE; counter reaching LOCK_FILTER-1 with ok=1 -> SYNC.
REQ-019 SYNC: cycle counter increments from 0; ok=0 -> IDLE; count reaching SYNC_CYCLES-1 -> RUN on next edge (exactly SYNC_CYCLES cycles in SYNC).
REQ-020 RUN: ok=0 -> IDLE and RESYNC_CNT increments (saturates at 255); FORCE_RESYNC=1 -> SYNC with counter cleared.
REQ-021 Simultaneous ok=0 and FORCE_RESYNC: lock loss wins (-> IDLE, count increments); FORCE_RESYNC outside RUN is ignored.
REQ-022 TRG_RST, LINK_READY registered: TRG_RST=0 and LINK_READY=1 exactly in cycles where STATE=RUN.
REQ-023 3-bit frame counter: 0 in every state except RUN; increments by 1 every RUN cycle, wraps 7->0.
REQ-024 TX_SEL = ~cnt[0]; first RUN cycle has TX_SEL=1.
REQ-025 FRM_SEP combinational from cnt[2:1]: 0->8'hBC, 1->8'hF7, 2->8'hFB, 3->8'hFD.
REQ-026 GEM_OVERFLOW=1 forces FRM_SEP=8'hFC in the same cycle, overriding REQ-025.

Reset
REQ-027 While TRG_TXRESETDONE=0: STATE=IDLE, TRG_RST=1, LINK_READY=0, TX_SEL=1, cnt=0, RESYNC_CNT=0, synchronizers and counters cleared.
REQ-028 FRM_SEP during reset = 8'hBC (8'hFC if GEM_OVERFLOW=1).
REQ-029 Reset assertion mid-RUN shall immediately return to IDLE without incrementing RESYNC_CNT; release is synchronized to TRG_CLK80.

Configuration
REQ-030 Macro TRIG_LINK_BC0_MARK_EN defined: BC0=1 in RUN forces FRM_SEP=8'h50 (priority over GEM_OVERFLOW) and loads cnt=1 on the next edge, realigning the K-code cycle to BX0.
REQ-031 Macro undefined: BC0 is ignored; FRM_SEP follows REQ-025/026 only.

Structure
REQ-032 Package trig_link_pkg holds the state encoding and K-code constants (BC, F7, FB, FD, FC, 50).
REQ-033 Sub-module trig_link_lock_filter holds the synchronizers and the LOCK_WAIT stability counter, outputting ok and filtered-done.

Verification
REQ-034 Reset release, PLL_LOCK=TX_SYNC_DONE=1 constant, defaults -> LINK_READY rises 2+16+256 cycles (+1 register) after release; TRG_RST=1 throughout.
REQ-035 RUN, GEM_OVERFLOW=0 -> FRM_SEP sequence BC,BC,F7,F7,FB,FB,FD,FD repeating; TX_SEL 1,0,1,0...
REQ-036 RUN, GEM_OVERFLOW=1 for one cycle at cnt=4 -> FRM_SEP=FC that cycle, FB next cycle.
REQ-037 PLL_LOCK drops for 1 cycle in RUN -> IDLE after 2-cycle sync delay, RESYNC_CNT 0->1, TRG_RST=1; 300 drops -> RESYNC_CNT=255.
REQ-038 FORCE_RESYNC and PLL_LOCK drop same cycle -> IDLE, count increments; FORCE_RESYNC alone -> exactly 256 SYNC cycles then RUN.
REQ-039 With TRIG_LINK_BC0_MARK_EN, BC0 at cnt=5 -> FRM_SEP=50, then cnt=1 (BC, TX_SEL=0) next cycle.
